// File: rtl/demux8_scheduler.sv
// demux8_scheduler: single-entry front end for the 1-to-8 demux tree.
// Holds one word, steers it to a lane chosen by destination field or by a
// round-robin pointer over enabled lanes, and counts words discarded
// because their addressed lane is disabled.
module demux8_scheduler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [2:0]   in_dest,
  input  logic         rr_mode,
  input  logic [7:0]   lane_en,
  output logic [7:0]   out_valid,
  input  logic [7:0]   out_ready,
  output logic [W-1:0] out_data,
  output logic [2:0]   sel,
  output logic [7:0]   drop_cnt
);

  // First enabled lane at or after ptr, scanning upward with wrap.
  // Returns ptr when no lane is enabled; callers gate on |en.
  function automatic logic [2:0] rr_pick(input logic [2:0] ptr, input logic [7:0] en);
    logic [2:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && en[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  logic         full_r;
  logic [W-1:0] data_r;
  logic [2:0]   sel_r;
  logic [2:0]   ptr_r;
  logic [7:0]   drop_r;

  logic         slot_free_s;
  logic         accept_s;
  logic         drop_s;
  logic         load_s;
  logic         done_s;
  logic [2:0]   lane_s;
  logic [2:0]   rr_lane_s;

  // Acceptance decision, lane choice and drop detection for the offered word.
  always_comb begin
    rr_lane_s   = rr_pick(ptr_r, lane_en);
    slot_free_s = !full_r || out_ready[sel_r];
    done_s      = full_r && out_ready[sel_r];
    if (rr_mode) begin
      in_ready = !rst && slot_free_s && (|lane_en);
      lane_s   = rr_lane_s;
    end else begin
      in_ready = !rst && slot_free_s;
      lane_s   = in_dest;
    end
    accept_s = in_valid && in_ready;
    drop_s   = accept_s && !rr_mode && !lane_en[in_dest];
    load_s   = accept_s && !drop_s;
  end

  // Holding register, lane select, round-robin pointer and drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_r <= 1'b0;
      data_r <= '0;
      sel_r  <= 3'd0;
      ptr_r  <= 3'd0;
      drop_r <= 8'd0;
    end else begin
      if (load_s) begin
        full_r <= 1'b1;
        data_r <= in_data;
        sel_r  <= lane_s;
      end else if (done_s) begin
        full_r <= 1'b0;
      end else begin
        full_r <= full_r;
      end
      if (load_s && rr_mode) begin
        ptr_r <= lane_s + 3'd1;
      end else begin
        ptr_r <= ptr_r;
      end
      if (drop_s && (drop_r != 8'hFF)) begin
        drop_r <= drop_r + 8'd1;
      end else begin
        drop_r <= drop_r;
      end
    end
  end

  // Lane strobes decoded only from registered state so lanes see one-hot or zero.
  always_comb begin
    if (full_r) begin
      out_valid = 8'd1 << sel_r;
    end else begin
      out_valid = 8'd0;
    end
  end

  assign out_data = data_r;
  assign sel      = sel_r;
  assign drop_cnt = drop_r;

endmodule

// File: tb/tb_demux8_scheduler.sv
// Directed self-checking bench for demux8_scheduler.
module tb_demux8_scheduler;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_dest;
  logic       rr_mode;
  logic [7:0] lane_en;
  logic [7:0] out_valid;
  logic [7:0] out_ready;
  logic [7:0] out_data;
  logic [2:0] sel;
  logic [7:0] drop_cnt;

  int total;
  int bad;

  demux8_scheduler #(.W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dest(in_dest), .rr_mode(rr_mode), .lane_en(lane_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sel(sel), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] rr_exp [4];
    total = 0;
    bad = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_dest = 3'd0;
    rr_mode = 1'b0; lane_en = 8'hFF; out_ready = 8'hFF;
    tick(); tick();
    rst = 1'b0;

    // 1: reset while a word is held
    in_valid = 1'b1; in_dest = 3'd1; in_data = 8'h77; out_ready = 8'h00;
    tick();
    in_valid = 1'b0;
    #1;
    chk("hold_valid", out_valid, 8'h02);
    chk("hold_data", out_data, 8'h77);
    rst = 1'b1;
    #1;
    chk("rst_ready_comb", 8'(in_ready), 8'h00);
    tick(); tick();
    chk("rst_valid", out_valid, 8'h00);
    chk("rst_ready", 8'(in_ready), 8'h00);
    chk("rst_drop", drop_cnt, 8'h00);
    chk("rst_data", out_data, 8'h00);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 8'(in_ready), 8'h01);

    // 2: addressed back-to-back
    out_ready = 8'hFF; lane_en = 8'hFF; rr_mode = 1'b0;
    in_valid = 1'b1; in_dest = 3'd5; in_data = 8'hA5;
    #1;
    chk("b2b_ready0", 8'(in_ready), 8'h01);
    tick();
    in_dest = 3'd2; in_data = 8'h3C;
    #1;
    chk("b2b_valid1", out_valid, 8'h20);
    chk("b2b_data1", out_data, 8'hA5);
    chk("b2b_ready1", 8'(in_ready), 8'h01);
    tick();
    in_valid = 1'b0;
    #1;
    chk("b2b_valid2", out_valid, 8'h04);
    chk("b2b_data2", out_data, 8'h3C);
    chk("b2b_ready2", 8'(in_ready), 8'h01);
    tick();
    chk("b2b_drain", out_valid, 8'h00);

    // 3: round-robin with skip and wrap over lanes 0,4,7
    rr_exp[0] = 8'h01; rr_exp[1] = 8'h10; rr_exp[2] = 8'h80; rr_exp[3] = 8'h01;
    lane_en = 8'h91; rr_mode = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 8'h10 + 8'(k);
      tick();
      chk("rr_lane", out_valid, rr_exp[k]);
      chk("rr_data", out_data, 8'h10 + 8'(k));
    end
    // ptr should now be 1: with all lanes enabled the next word lands on lane 1
    lane_en = 8'hFF; in_data = 8'h55;
    tick();
    chk("rr_ptr_lane", out_valid, 8'h02);
    chk("rr_ptr_sel", 8'(sel), 8'h01);
    in_valid = 1'b0; rr_mode = 1'b0;
    tick();
    chk("rr_drain", out_valid, 8'h00);

    // 4: backpressure on lane 3, a second word waits
    out_ready = 8'hF7; in_valid = 1'b1; in_dest = 3'd3; in_data = 8'hC3;
    tick();
    in_dest = 3'd6; in_data = 8'h99; lane_en = 8'h00;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_valid", out_valid, 8'h08);
      chk("bp_data", out_data, 8'hC3);
      chk("bp_ready", 8'(in_ready), 8'h00);
      tick();
    end
    lane_en = 8'hFF; out_ready = 8'hFF;
    #1;
    chk("bp_release_ready", 8'(in_ready), 8'h01);
    tick();
    in_valid = 1'b0;
    #1;
    chk("bp_next_valid", out_valid, 8'h40);
    chk("bp_next_data", out_data, 8'h99);
    tick();
    chk("bp_drain", out_valid, 8'h00);

    // 5: drops to a disabled addressed lane, counter saturates
    lane_en = 8'hFE; rr_mode = 1'b0; in_dest = 3'd0; in_valid = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      in_data = 8'(k);
      tick();
      chk("drop_valid", out_valid, 8'h00);
      if (k == 10) chk("drop_cnt10", drop_cnt, 8'h0A);
      if (k == 254) chk("drop_cnt254", drop_cnt, 8'hFE);
      if (k == 255) chk("drop_cnt255", drop_cnt, 8'hFF);
      if (k == 300) chk("drop_cnt300", drop_cnt, 8'hFF);
    end
    in_valid = 1'b0;
    tick();

    // 6: round-robin with every lane disabled, then lane 6 only
    rr_mode = 1'b1; lane_en = 8'h00;
    #1;
    chk("rr_none_ready", 8'(in_ready), 8'h00);
    in_valid = 1'b1; in_data = 8'h66;
    tick();
    chk("rr_none_valid", out_valid, 8'h00);
    lane_en = 8'h40;
    #1;
    chk("rr_one_ready", 8'(in_ready), 8'h01);
    tick();
    in_valid = 1'b0;
    #1;
    chk("rr_one_valid", out_valid, 8'h40);
    chk("rr_one_data", out_data, 8'h66);
    chk("rr_one_sel", 8'(sel), 8'h06);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
